// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the high time of a 128-tick servo frame in clk
// ticks and reports it as a 7-bit position with a one-cycle valid strobe.
// A timeout flags loss of signal when no rising edge arrives for too long.
// Optional build macro SERVO_PWM_DEGLITCH_EN adds a 3-sample deglitch filter
// after the synchronizer (adds 2 cycles of latency, preserves pulse width).
module servo_pwm_decoder #(
    parameter int TIMEOUT_TICKS = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [6:0] position,
    output logic       valid,
    output logic       saturated,
    output logic       signal_lost
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2
    } state_t;

`ifdef SERVO_PWM_DEGLITCH_EN
    // Synchronizer plus two history flops must all hold real samples
    localparam int PRIME_DEPTH = 4;
`else
    localparam int PRIME_DEPTH = 2;
`endif
    localparam logic [9:0] TIMEOUT_LIMIT = 10'(TIMEOUT_TICKS);

    logic                   sync1;
    logic                   sync2;
    logic                   pwm_s;
    logic                   pwm_prev;
    logic [PRIME_DEPTH-1:0] prime;
    logic                   rise;
    logic                   fall;
    logic                   timeout_hit;
    state_t                 state;
    logic [7:0]             high_count;
    logic [9:0]             timeout_count;

`ifdef SERVO_PWM_DEGLITCH_EN
    logic hist1;
    logic hist2;

    // Filtered level follows the input only once three samples agree;
    // otherwise it holds the previously accepted level.
    always_comb begin
        pwm_s = pwm_prev;
        if (sync2 && hist1 && hist2)
            pwm_s = 1'b1;
        else if (!sync2 && !hist1 && !hist2)
            pwm_s = 1'b0;
    end

    // Sample history for the deglitch vote
    always_ff @(posedge clk) begin
        if (reset) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
        end
    end
`else
    assign pwm_s = sync2;
`endif

    // Two-flop synchronizer, previous-level register and pipeline-primed flags
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            pwm_prev <= 1'b0;
            prime    <= '0;
        end else begin
            // NOTE: non-blocking assignments let sync2 take the old sync1,
            // giving a true two-stage pipeline regardless of statement order.
            sync1    <= pwm_in;
            sync2    <= sync1;
            pwm_prev <= pwm_s;
            prime    <= {prime[PRIME_DEPTH-2:0], 1'b1};
        end
    end

    assign rise = pwm_s && !pwm_prev;
    assign fall = !pwm_s && pwm_prev;
    // A rise in the same cycle always wins over an expiring timeout
    assign timeout_hit = !rise && (timeout_count == TIMEOUT_LIMIT - 10'd1);

    // Capture FSM with timeout supervision and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SYNC;
            high_count    <= '0;
            timeout_count <= '0;
            position      <= '0;
            saturated     <= 1'b0;
            valid         <= 1'b0;
            signal_lost   <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (rise)
                timeout_count <= '0;
            else if (timeout_count != TIMEOUT_LIMIT)
                timeout_count <= timeout_count + 10'd1;

            if (timeout_hit) begin
                // Abandon any pulse in progress, including a line stuck high
                signal_lost <= 1'b1;
                state       <= SYNC;
            end else begin
                case (state)
                    SYNC: begin
                        // Wait for a genuine low so a partial pulse is never measured
                        if (prime[PRIME_DEPTH-1] && !pwm_s)
                            state <= ARMED;
                    end
                    ARMED: begin
                        if (rise) begin
                            high_count <= 8'd1;
                            state      <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            position    <= (high_count > 8'd127) ? 7'd127 : high_count[6:0];
                            saturated   <= high_count[7];
                            valid       <= 1'b1;
                            signal_lost <= 1'b0;
                            state       <= ARMED;
                        end else if (pwm_s && high_count != 8'hFF) begin
                            high_count <= high_count + 8'd1;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder. Expected captures are queued
// when a pulse is driven and compared when valid strobes.
module tb_servo_pwm_decoder;

    localparam int TIMEOUT = 512;
`ifdef SERVO_PWM_DEGLITCH_EN
    localparam int LAT   = 5;
    localparam int MIN_W = 3;
`else
    localparam int LAT   = 3;
    localparam int MIN_W = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [6:0] position;
    logic       valid;
    logic       saturated;
    logic       signal_lost;

    servo_pwm_decoder #(.TIMEOUT_TICKS(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .position   (position),
        .valid      (valid),
        .saturated  (saturated),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        int sat;
        int due;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_rise = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Low phase, high phase, then a low tail; pos < 0 means no capture expected
    task automatic drive_pulse(input int low_n, input int high_n, input int pos, input int sat);
        pwm_in = 1'b0;
        wait_cycles(low_n);
        pwm_in    = 1'b1;
        last_rise = cycle;
        wait_cycles(high_n);
        pwm_in = 1'b0;
        if (pos >= 0)
            q.push_back('{pos, sat, cycle + LAT});
        wait_cycles(10);
    endtask

    // Scoreboard monitor: every valid must match the oldest queued capture
    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("position", int'(position), e.pos);
                check("saturated", int'(saturated), e.sat);
                check("latency", cycle, e.due);
                check("lost_on_valid", int'(signal_lost), 0);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        wait_cycles(3);
        check("rst_position", int'(position), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_saturated", int'(saturated), 0);
        check("rst_lost", int'(signal_lost), 0);
        reset = 1'b0;

        // Basic capture, minimum and maximum unsaturated widths
        drive_pulse(10, 64, 64, 0);
        drive_pulse(20, MIN_W, MIN_W, 0);
        drive_pulse(20, 127, 127, 0);
        drive_pulse(20, 128, 127, 1);

        // Saturation then recovery
        drive_pulse(20, 200, 127, 1);
        drive_pulse(20, 50, 50, 0);

        // Loss of signal while held low
        while (cycle < last_rise + TIMEOUT) @(negedge clk);
        check("lost_before_timeout", int'(signal_lost), 0);
        while (cycle < last_rise + TIMEOUT + 8) @(negedge clk);
        check("lost_after_timeout", int'(signal_lost), 1);
        check("hold_position_lost", int'(position), 50);
        check("hold_saturated_lost", int'(saturated), 0);
        wait_cycles(80);
        drive_pulse(0, 30, 30, 0);
        check("lost_cleared", int'(signal_lost), 0);

        // Reset in the middle of a pulse discards it
        pwm_in = 1'b0;
        wait_cycles(10);
        pwm_in = 1'b1;
        wait_cycles(20);
        reset = 1'b1;
        wait_cycles(2);
        check("midpulse_rst_position", int'(position), 0);
        reset = 1'b0;
        wait_cycles(68);
        pwm_in = 1'b0;
        wait_cycles(15);
        check("after_abort_position", int'(position), 0);
        drive_pulse(20, 45, 45, 0);

        // Line stuck high: timeout, no capture on the eventual fall
        pwm_in = 1'b0;
        wait_cycles(10);
        pwm_in = 1'b1;
        wait_cycles(TIMEOUT + 8);
        check("stuck_high_lost", int'(signal_lost), 1);
        wait_cycles(80);
        pwm_in = 1'b0;
        wait_cycles(15);
        check("stuck_high_still_lost", int'(signal_lost), 1);
        check("stuck_high_position", int'(position), 45);
        drive_pulse(20, 20, 20, 0);
        check("stuck_high_recovered", int'(signal_lost), 0);

`ifdef SERVO_PWM_DEGLITCH_EN
        // Short glitch in the low phase is filtered, then a normal pulse
        pwm_in = 1'b0;
        wait_cycles(10);
        pwm_in = 1'b1;
        wait_cycles(2);
        pwm_in = 1'b0;
        wait_cycles(20);
        check("glitch_position", int'(position), 20);
        drive_pulse(10, 40, 40, 0);
`else
        // Without the filter a 2-tick pulse is a real capture
        drive_pulse(20, 2, 2, 0);
        drive_pulse(10, 40, 40, 0);
`endif

        wait_cycles(10);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 512; clk cycles without a rising edge before the signal is declared lost.
REQ-002 clk  input  1  sole clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pwm_in  input  1  asynchronous servo PWM pulse train; 128-tick frame, high time in ticks encodes position.
REQ-005 position  output  7  last captured high time in clk ticks, saturated at 127.
REQ-006 valid  output  1  one-cycle strobe; position updated on this cycle.
REQ-007 saturated  output  1  last capture exceeded 127 ticks.
REQ-008 signal_lost  output  1  no rising edge seen for TIMEOUT_TICKS cycles.

Function
REQ-009 pwm_in SHALL pass through a 2-flop synchronizer; all edge detection uses the synchronized level (pwm_s).
REQ-010 Edge detection SHALL compare pwm_s with its previous-cycle value; rise = 0->1, fall = 1->0.
REQ-011 The FSM SHALL have states SYNC, ARMED and HIGH.
REQ-012 SYNC: wait for pwm_s = 0, then go to ARMED; no partial pulse after reset or timeout is ever captured.
REQ-013 ARMED: on rise, load the 8-bit high counter with 1 and go to HIGH.
REQ-014 HIGH: increment the high counter each cycle pwm_s = 1; saturate at 255, never wrap.
REQ-015 HIGH: on fall, position <= min(count, 127), saturated <= (count > 127), valid = 1 for exactly one cycle; go to ARMED.
REQ-016 A pulse high for N synchronized samples SHALL yield position = N for 1 <= N <= 127.
REQ-017 Latency: valid SHALL assert 3 clk cycles after the pwm_in falling edge (2 sync + 1 register), macro off.
REQ-018 A 10-bit timeout counter SHALL clear on every rise and increment otherwise, saturating at TIMEOUT_TICKS.
REQ-019 When the timeout counter reaches TIMEOUT_TICKS: signal_lost <= 1, FSM -> SYNC, position holds, no valid.
REQ-020 signal_lost SHALL clear on the next valid capture, in the same cycle valid asserts.
REQ-021 Line stuck high: timeout applies in HIGH as well; the FSM goes to SYNC and issues no capture.
REQ-022 position and saturated SHALL change only on valid cycles or reset.
REQ-023 A rise and a timeout in the same cycle: the rise wins, the counter clears and signal_lost is not set.

Reset
REQ-024 While reset = 1, the following SHALL hold on the next posedge:
- position = 0, valid = 0, saturated = 0, signal_lost = 0
- FSM = SYNC
- all counters, synchronizer and deglitch flops = 0
REQ-025 A reset asserted mid-pulse SHALL discard the pulse; the first capture after reset requires a full low-high-low sequence.

Configuration
REQ-026 Macro SERVO_PWM_DEGLITCH_EN selects the deglitch filter.
REQ-027 With SERVO_PWM_DEGLITCH_EN defined:
- pwm_s changes level only after 3 consecutive equal synchronized samples
- pulses or gaps shorter than 3 cycles are ignored
- latency becomes 5 cycles; width is preserved
REQ-028 Without SERVO_PWM_DEGLITCH_EN: no filter logic is present and REQ-017 latency applies.

Verification
REQ-029 After reset, pwm_in low 10 cycles, then high 64, then low -> valid once 3 cycles after the fall, position = 64, saturated = 0.
REQ-030 Frames with high time 1, then 127 -> position = 1 then 127; saturated = 0 both times.
REQ-031 High time 200 -> position = 127, saturated = 1; a next pulse of 50 -> position = 50, saturated = 0.
REQ-032 pwm_in held low 600 cycles -> signal_lost = 1 at cycle 512 after the last rise; a following 30-tick pulse -> valid, position = 30, signal_lost = 0.
REQ-033 Reset asserted 20 cycles into a 90-tick pulse -> no valid for that pulse; position = 0 until the next complete pulse.
REQ-034 Macro defined: 2-cycle glitch inside the low phase -> no valid; a 40-tick pulse -> position = 40, valid 5 cycles after the fall.
